// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and helpers for the keypad scanner.
//                - scan_state_t : scan FSM states (SCAN / DEBOUNCE / HELD)
//                - key_width()  : bit width of a key code for a ROWS x COLS pad
//                - IDLE_ROW     : row index driven out of reset
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  // Row driven after reset; the idle pattern on ROW_OUT is a one-hot of this.
  localparam int unsigned IDLE_ROW = 0;

  // Key code width; at least one bit so a 1x1 pad still has a legal bus.
  function automatic int unsigned key_width(input int unsigned rows,
                                            input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_fifo
//  Description : Small synchronous FIFO for key codes.
//                A push while full succeeds only if a pop happens in the same
//                cycle; a pop while empty is ignored. head_o reads 0 when empty.
//  Ports       : clk_i, rst_i (sync, active high)
//                push_i/data_i  - write request and data
//                pop_i          - dequeue head
//                head_o         - current head entry (0 when empty)
//                full_o/empty_o - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             w_pop;
  logic             w_wr;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    w_pop   = pop_i && !empty_o;
    w_wr    = push_i && (!full_o || w_pop);
    head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_wr)  wr_q <= wr_q + 1'b1;
      if (w_pop) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_fifo
//  Description : ROWS x COLS matrix keypad scanner with debounce, key-code
//                FIFO, timed interrupt pulse and sticky overflow flag.
//                Optional build macro KEYPAD_REPEAT_EN adds auto-repeat
//                (parameter REPEAT_SCANS) while a key stays held.
//  Ports       : CLK, RST (sync, active high)
//                COL_IN    - column sense lines, active high
//                ROW_OUT   - one-hot row drive
//                KEY_POP   - dequeue FIFO head
//                KEY_DATA  - FIFO head code (r*COLS+c), 0 when empty
//                KEY_VALID - FIFO not empty
//                INTR      - INTR_LEN-cycle pulse per accepted key
//                OVERFLOW  - sticky, a key was dropped on a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 3,
  parameter int unsigned SCAN_DIV   = 10,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INTR_LEN   = 2
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 50
`endif
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [COLS-1:0]                     COL_IN,
  output logic [ROWS-1:0]                     ROW_OUT,
  input  logic                                KEY_POP,
  output logic [key_width(ROWS, COLS)-1:0]    KEY_DATA,
  output logic                                KEY_VALID,
  output logic                                INTR,
  output logic                                OVERFLOW
);

  localparam int unsigned KW   = key_width(ROWS, COLS);
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW   = $clog2(SCAN_DIV);
  localparam int unsigned CNTW = $clog2(DEBOUNCE + 1);
  localparam int unsigned IW   = $clog2(INTR_LEN + 1);

  scan_state_t     state_q, state_d;
  logic [RW-1:0]   row_q,   row_d;
  logic [CW-1:0]   col_q,   col_d;
  logic [KW-1:0]   code_q,  code_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0]   div_q,   div_d;
  logic [IW-1:0]   intr_q,  intr_d;
  logic            ovf_q,   ovf_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REPW = $clog2(REPEAT_SCANS + 1);
  logic [REPW-1:0] rep_q,   rep_d;
`endif

  logic            w_tick;
  logic            w_any;
  logic [CW-1:0]   w_col;
  logic [KW-1:0]   w_code;
  logic            w_push;
  logic            w_full;
  logic            w_empty;

  // Lowest-numbered active column wins.
  always_comb begin
    w_any = |COL_IN;
    w_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (COL_IN[c]) w_col = CW'(c);
    end
    w_code = KW'(int'(row_q) * int'(COLS) + int'(w_col));
    w_tick = (div_q == DW'(SCAN_DIV - 1));
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SCAN;
      row_q   <= RW'(IDLE_ROW);
      col_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      intr_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      intr_q  <= intr_d;
      ovf_q   <= ovf_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every decision happens on the sample tick, the last
  // cycle of a SCAN_DIV window; the divider free-runs across all states.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    div_d   = w_tick ? '0 : div_q + 1'b1;
    w_push  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = (state_q == ST_HELD) ? rep_q : '0;
`endif

    if (w_tick) begin
      case (state_q)
        ST_SCAN: begin
          if (w_any) begin
            code_d = w_code;
            col_d  = w_col;
            if (DEBOUNCE == 1) begin
              w_push  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNTW'(1);
            end
          end else begin
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (w_any && (w_col == col_q)) begin
            if (cnt_q == CNTW'(DEBOUNCE - 1)) begin
              w_push  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Unstable: retry this row without advancing.
            state_d = ST_SCAN;
            cnt_d   = '0;
          end
        end

        ST_HELD: begin
          if (w_any) begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == REPW'(REPEAT_SCANS - 1)) begin
              w_push = 1'b1;
              rep_d  = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (cnt_q == CNTW'(DEBOUNCE - 1)) begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end

    // A new push restarts the pulse even if one is already running.
    if (w_push)              intr_d = IW'(INTR_LEN);
    else if (intr_q != '0)   intr_d = intr_q - 1'b1;
    else                     intr_d = '0;

    ovf_d = ovf_q | (w_push && w_full && !KEY_POP);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      ROW_OUT[r] = (row_q == RW'(r));
    end
    KEY_VALID = !w_empty;
    INTR      = (intr_q != '0);
    OVERFLOW  = ovf_q;
  end

  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (w_push),
    .data_i  (code_d),
    .pop_i   (KEY_POP),
    .head_o  (KEY_DATA),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_fifo
//  Description : Directed self-checking bench for keypad_scan_fifo with a
//                physical keypad model (pressed key connects row to column).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] COL_IN;
  logic [3:0] ROW_OUT;
  logic       KEY_POP = 1'b0;
  logic [3:0] KEY_DATA;
  logic       KEY_VALID;
  logic       INTR;
  logic       OVERFLOW;

  logic [11:0] keys = '0;
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    COL_IN = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && ROW_OUT[r]) COL_IN[c] = 1'b1;
  end

  keypad_scan_fifo dut (
    .CLK       (CLK),
    .RST       (RST),
    .COL_IN    (COL_IN),
    .ROW_OUT   (ROW_OUT),
    .KEY_POP   (KEY_POP),
    .KEY_DATA  (KEY_DATA),
    .KEY_VALID (KEY_VALID),
    .INTR      (INTR),
    .OVERFLOW  (OVERFLOW)
  );

  task automatic do_reset();
    keys    = '0;
    KEY_POP = 1'b0;
    RST     = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic press(input int code, input int hold);
    keys[code] = 1'b1;
    repeat (hold) @(negedge CLK);
    keys[code] = 1'b0;
    repeat (60) @(negedge CLK);
  endtask

  task automatic pop_one();
    KEY_POP = 1'b1;
    @(negedge CLK);
    KEY_POP = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < limit) begin
      @(negedge CLK);
      cyc++;
      if (KEY_VALID) ok = 1'b1;
    end
  endtask

  // Waits for the wrap 1000 -> 0001, i.e. just after a row-0 window starts.
  task automatic sync_row0(output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = ROW_OUT;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (ROW_OUT == 4'b0001 && prev == 4'b1000) ok = 1'b1;
      prev = ROW_OUT;
    end
  endtask

  task automatic test_reset();
    keys = '0;
    RST  = 1'b1;
    @(negedge CLK);
    checks++;
    if (ROW_OUT !== 4'b0001 || KEY_VALID !== 1'b0 || INTR !== 1'b0 ||
        KEY_DATA !== 4'd0 || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got row=%b v=%b i=%b d=%0d o=%b required row=0001 v=0 i=0 d=0 o=0",
               ROW_OUT, KEY_VALID, INTR, KEY_DATA, OVERFLOW);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 50; k++) begin
      logic [3:0] exp_row;
      exp_row = 4'b0001 << ((k / 10) % 4);
      checks++;
      if (ROW_OUT !== exp_row || KEY_VALID !== 1'b0 || INTR !== 1'b0) begin
        failures++;
        $display("FAIL idle_scan k=%0d got row=%b v=%b i=%b required row=%b v=0 i=0",
                 k, ROW_OUT, KEY_VALID, INTR, exp_row);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int cyc;
    keys[7] = 1'b1;
    wait_valid(200, ok, cyc);
    checks++;
    if (!ok || cyc > 71) begin
      failures++;
      $display("FAIL single_latency got ok=%0d cycles=%0d required ok=1 cycles<=71", ok, cyc);
    end
    checks++;
    if (KEY_DATA !== 4'd7 || INTR !== 1'b1) begin
      failures++;
      $display("FAIL single_first got d=%0d i=%b required d=7 i=1", KEY_DATA, INTR);
    end
    @(negedge CLK);
    checks++;
    if (INTR !== 1'b1) begin
      failures++;
      $display("FAIL intr_second_cycle got %b required 1", INTR);
    end
    @(negedge CLK);
    checks++;
    if (INTR !== 1'b0) begin
      failures++;
      $display("FAIL intr_end got %b required 0", INTR);
    end
    repeat (200 - cyc - 2) @(negedge CLK);
    keys[7] = 1'b0;
    repeat (60) @(negedge CLK);
    checks++;
    if (KEY_VALID !== 1'b1 || KEY_DATA !== 4'd7) begin
      failures++;
      $display("FAIL single_hold got v=%b d=%0d required v=1 d=7", KEY_VALID, KEY_DATA);
    end
    pop_one();
    checks++;
    if (KEY_VALID !== 1'b0 || KEY_DATA !== 4'd0) begin
      failures++;
      $display("FAIL single_popped got v=%b d=%0d required v=0 d=0", KEY_VALID, KEY_DATA);
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int cyc;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      repeat (10) @(negedge CLK);
    end
    checks++;
    if (KEY_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reject got v=%b required 0", KEY_VALID);
    end
    keys[3] = 1'b1;
    wait_valid(200, ok, cyc);
    checks++;
    if (!ok || cyc > 71 || KEY_DATA !== 4'd3) begin
      failures++;
      $display("FAIL bounce_accept got ok=%0d cycles=%0d d=%0d required ok=1 cycles<=71 d=3",
               ok, cyc, KEY_DATA);
    end
    repeat (200) @(negedge CLK);
    keys[3] = 1'b0;
    repeat (60) @(negedge CLK);
    pop_one();
    checks++;
    if (KEY_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bounce_single_push got v=%b required 0", KEY_VALID);
    end
  endtask

  task automatic test_overflow();
    int codes[5] = '{0, 4, 8, 11, 2};
    for (int i = 0; i < 4; i++) press(codes[i], 100);
    checks++;
    if (OVERFLOW !== 1'b0 || KEY_VALID !== 1'b1) begin
      failures++;
      $display("FAIL fill_four got o=%b v=%b required o=0 v=1", OVERFLOW, KEY_VALID);
    end
    press(codes[4], 100);
    checks++;
    if (OVERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got %b required 1", OVERFLOW);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (KEY_VALID !== 1'b1 || KEY_DATA !== codes[i][3:0]) begin
        failures++;
        $display("FAIL overflow_pop%0d got v=%b d=%0d required v=1 d=%0d",
                 i, KEY_VALID, KEY_DATA, codes[i]);
      end
      pop_one();
    end
    checks++;
    if (KEY_VALID !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drained got v=%b required 0", KEY_VALID);
    end
    pop_one();
    checks++;
    if (KEY_VALID !== 1'b0 || KEY_DATA !== 4'd0 || OVERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL empty_pop got v=%b d=%0d o=%b required v=0 d=0 o=1",
               KEY_VALID, KEY_DATA, OVERFLOW);
    end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    int exp_codes[4] = '{4, 8, 11, 1};
    do_reset();
    press(0, 100);
    press(4, 100);
    press(8, 100);
    press(11, 100);
    sync_row0(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL pp_sync got 0 required 1");
    end
    // Code 1 (row 0, col 1) is accepted on the 30th edge after this point.
    keys[1] = 1'b1;
    repeat (29) @(negedge CLK);
    KEY_POP = 1'b1;
    @(negedge CLK);
    KEY_POP = 1'b0;
    checks++;
    if (INTR !== 1'b1 || OVERFLOW !== 1'b0 || KEY_DATA !== 4'd4) begin
      failures++;
      $display("FAIL pp_accept got i=%b o=%b d=%0d required i=1 o=0 d=4",
               INTR, OVERFLOW, KEY_DATA);
    end
    repeat (40) @(negedge CLK);
    keys[1] = 1'b0;
    repeat (60) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (KEY_VALID !== 1'b1 || KEY_DATA !== exp_codes[i][3:0]) begin
        failures++;
        $display("FAIL pp_pop%0d got v=%b d=%0d required v=1 d=%0d",
                 i, KEY_VALID, KEY_DATA, exp_codes[i]);
      end
      pop_one();
    end
    checks++;
    if (KEY_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL pp_drained got v=%b o=%b required v=0 o=0", KEY_VALID, OVERFLOW);
    end
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    do_reset();
    repeat (5) @(negedge CLK);
    sync_row0(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rd_sync got 0 required 1");
    end
    keys[0] = 1'b1;
    repeat (19) @(negedge CLK);
    RST     = 1'b1;
    keys[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ROW_OUT !== 4'b0001 || KEY_VALID !== 1'b0 || INTR !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_reset got row=%b v=%b i=%b required row=0001 v=0 i=0",
               ROW_OUT, KEY_VALID, INTR);
    end
    RST = 1'b0;
    repeat (150) @(negedge CLK);
    checks++;
    if (KEY_VALID !== 1'b0 || INTR !== 1'b0) begin
      failures++;
      $display("FAIL rd_no_push got v=%b i=%b required v=0 i=0", KEY_VALID, INTR);
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    do_reset();
    press(5, 600);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (KEY_VALID !== 1'b1 || KEY_DATA !== 4'd5) begin
        failures++;
        $display("FAIL repeat_pop%0d got v=%b d=%0d required v=1 d=5", i, KEY_VALID, KEY_DATA);
      end
      pop_one();
    end
    checks++;
    if (KEY_VALID !== 1'b0) begin
      failures++;
      $display("FAIL repeat_count got v=%b required 0", KEY_VALID);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_debounce();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised successor to the single-key keypad driver.
- Scans a ROWS x COLS matrix keypad with time-multiplexed row drive, debounces presses and encodes each press as a key index.
- Buffers key codes in a FIFO with a pop handshake and raises a timed interrupt pulse per accepted key.
- Sits between the keypad pins and the MCU interrupt/IO-port logic; replaces the free-standing clock divider, one-deep hold register and interrupt FSM.

Parameters:
ROWS, 4, number of driven row lines
COLS, 3, number of sensed column lines
SCAN_DIV, 10, CLK cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE, 3, consecutive identical samples required to accept a press or a release (>=1)
FIFO_DEPTH, 4, key-code buffer entries (power of 2, >=2)
INTR_LEN, 2, CLK cycles INTR stays high per accepted key (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
COL_IN  in  COLS  column sense lines, active high (pulled down externally)
ROW_OUT  out  ROWS  one-hot row drive, active high
KEY_POP  in  1  consumer acknowledges the head entry; dequeue on this cycle
KEY_DATA  out  KW  FIFO head code; KW = $clog2(ROWS*COLS)
KEY_VALID  out  1  FIFO not empty
INTR  out  1  interrupt pulse
OVERFLOW  out  1  sticky: a key was dropped because the FIFO was full

Behaviour:
- Reset values: ROW_OUT=1 (row 0), KEY_DATA=0, KEY_VALID=0, INTR=0, OVERFLOW=0. FIFO pointers, counters and state are cleared. Reset mid-scan or mid-debounce abandons the candidate key; nothing is pushed.
- Key code = r*COLS + c. When several columns are high, the lowest c wins.
- SCAN: drive row r for SCAN_DIV cycles; sample COL_IN on the last cycle.
  - All columns low: r <= (r==ROWS-1) ? 0 : r+1.
  - Otherwise latch the code and go to DEBOUNCE with cnt=1.
- DEBOUNCE: hold row r. Resample every SCAN_DIV cycles.
  - Same column high: cnt++. When cnt==DEBOUNCE, push the code and go to HELD.
  - Column changed or all low: return to SCAN on the same row.
  - With DEBOUNCE=1, the push happens on the first sample.
- HELD: hold row r; resample every SCAN_DIV cycles. DEBOUNCE consecutive all-low samples go to SCAN and advance the row. Any high sample resets the release count.
- Push: the code is written to the FIFO on the cycle of acceptance. KEY_VALID rises the next cycle. INTR goes high that next cycle for exactly INTR_LEN cycles. A push during an active pulse restarts the INTR_LEN count.
- FIFO:
  - KEY_DATA always shows the head; it is 0 when empty.
  - KEY_POP while empty is ignored.
  - Push and pop in the same cycle while full: both succeed, OVERFLOW is unchanged.
  - Push while full with no pop: the code is dropped and OVERFLOW is set. OVERFLOW clears only on RST.
  - Push into empty with simultaneous pop: the pop is ignored and the push is stored.
- Latency from a stable press onset to KEY_VALID is at most (ROWS+DEBOUNCE)*SCAN_DIV+1 cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: adds parameter REPEAT_SCANS (default 50). In HELD, after REPEAT_SCANS consecutive high samples, the same code is pushed again (with an INTR pulse) and the counter restarts. Overflow rules apply to repeats.
- Undefined: exactly one push per press; the repeat counter is not synthesised.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, HELD};
  - the function for the code width KW;
  - a localparam for the idle row pattern.
- Sub-module key_fifo (parametrised width/depth, push/pop/full/empty/head) is instantiated once. The scan FSM, debounce counters and INTR timer stay in the top.

Test Plan:
- Reset/idle, defaults: RST high for 2 cycles, no keys → ROW_OUT cycles 0001→0010→0100→1000→0001 every 10 CLK; KEY_VALID=0, INTR=0.
- Single press: key at row 2, col 1 held 200 cycles → exactly one push with KEY_DATA=7; INTR high 2 cycles; KEY_VALID stays 1 until KEY_POP, then drops to 0.
- Bounce rejection: col 0 on row 1 toggles each 10-cycle sample for 100 cycles, then stable → only one push, code 3, after 3 stable samples.
- FIFO full/overflow: 5 distinct presses (codes 0,4,8,11,2) with no pop → the first 4 are buffered in order, OVERFLOW=1, code 2 is lost. Then pop 4 times → data 0,4,8,11 in that order, then KEY_VALID=0.
- Simultaneous push/pop when full: FIFO full, KEY_POP asserted on the acceptance cycle → count stays 4, OVERFLOW stays 0, new code at the tail.
- Reset mid-debounce: RST at the 2nd debounce sample → no push, ROW_OUT=0001 next cycle. With KEYPAD_REPEAT_EN defined, a key held for 60 samples → 2 pushes.
